// File: rtl/ahb_req_arbiter.sv
// ahb_req_arbiter: round-robin arbiter that shares one AHB-lite slave port
// between NUM_MASTERS local requesters, one single NONSEQ transfer per grant.
// Ports: Hclk, Hreset (sync, active-high); per-master m_req/m_addr/m_write/
//   m_wdata in, m_gnt/m_ack out; m_err/m_rdata completion status; busy;
//   Haddr/Hwrite/Htrans/Hwdata/Hreadyin to the bridge, Hreadyout/Hresp/Hrdata
//   from it.
// Optional: define ARB_TIMEOUT_EN to force completion with m_err=1 after
//   TIMEOUT_CYCLES stalled cycles in ADDR or DATA.
module ahb_req_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      Hclk,
   input  logic                      Hreset,
   input  logic [NUM_MASTERS-1:0]    m_req,
   input  logic [NUM_MASTERS*32-1:0] m_addr,
   input  logic [NUM_MASTERS-1:0]    m_write,
   input  logic [NUM_MASTERS*32-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]    m_gnt,
   output logic [NUM_MASTERS-1:0]    m_ack,
   output logic                      m_err,
   output logic [31:0]               m_rdata,
   output logic                      busy,
   output logic [31:0]               Haddr,
   output logic                      Hwrite,
   output logic [1:0]                Htrans,
   output logic [31:0]               Hwdata,
   output logic                      Hreadyin,
   input  logic                      Hreadyout,
   input  logic [1:0]                Hresp,
   input  logic [31:0]               Hrdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA
   } state_t;

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;

   state_t                   state_q, state_d;
   logic [1:0]               rr_ptr_q, rr_ptr_d;
   logic [1:0]               idx_q, idx_d;
   logic [NUM_MASTERS-1:0]   gnt_q, gnt_d;
   logic [NUM_MASTERS-1:0]   ack_q, ack_d;
   logic                     err_q, err_d;
   logic [31:0]              rdata_q, rdata_d;
   logic [31:0]              addr_q, addr_d;
   logic                     write_q, write_d;
   logic [31:0]              wdata_q, wdata_d;
`ifdef ARB_TIMEOUT_EN
   logic [15:0]              cnt_q, cnt_d;
`endif

   logic                     sel_found;
   logic [1:0]               sel_idx;
   logic [31:0]              sel_addr;
   logic [31:0]              sel_wdata;
   logic                     sel_write;
   logic                     cpl;
   logic                     cpl_err;
   logic                     cpl_cap;

   // First requester at or after rr_ptr, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (!sel_found && m_req[(int'(rr_ptr_q) + k) % NUM_MASTERS]) begin
            sel_found = 1'b1;
            sel_idx   = 2'((int'(rr_ptr_q) + k) % NUM_MASTERS);
         end
      end
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (sel_idx == 2'(i)) begin
            sel_addr  = m_addr[32*i +: 32];
            sel_wdata = m_wdata[32*i +: 32];
            sel_write = m_write[i];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      idx_d    = idx_q;
      gnt_d    = gnt_q;
      ack_d    = '0;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      cpl      = 1'b0;
      cpl_err  = 1'b0;
      cpl_cap  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               state_d = S_ADDR;
               idx_d   = sel_idx;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               write_d = sel_write;
               for (int i = 0; i < NUM_MASTERS; i++) begin
                  gnt_d[i] = (sel_idx == 2'(i));
               end
`ifdef ARB_TIMEOUT_EN
               cnt_d = '0;
`endif
            end
         end
         S_ADDR: begin
            if (Hreadyout) begin
               state_d = S_DATA;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
               cpl     = 1'b1;
               cpl_err = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         S_DATA: begin
            if (Hreadyout) begin
               cpl     = 1'b1;
               cpl_err = (Hresp != 2'b00);
               cpl_cap = !write_q;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
               cpl     = 1'b1;
               cpl_err = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase

      // Ack is registered, so the ack cycle itself is spent in IDLE.
      if (cpl) begin
         state_d  = S_IDLE;
         ack_d    = gnt_q;
         err_d    = cpl_err;
         gnt_d    = '0;
         rr_ptr_d = (idx_q == 2'(NUM_MASTERS - 1)) ? 2'd0 : idx_q + 2'd1;
         if (cpl_cap) begin
            rdata_d = Hrdata;
         end
      end
   end

   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         idx_q    <= '0;
         gnt_q    <= '0;
         ack_q    <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         idx_q    <= idx_d;
         gnt_q    <= gnt_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign m_gnt    = gnt_q;
   assign m_ack    = ack_q;
   assign m_err    = err_q;
   assign m_rdata  = rdata_q;
   assign busy     = (state_q != S_IDLE);
   assign Haddr    = addr_q;
   assign Hwrite   = write_q;
   assign Htrans   = (state_q == S_ADDR) ? HT_NONSEQ : HT_IDLE;
   assign Hwdata   = wdata_q;
   assign Hreadyin = 1'b1;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// tb_ahb_req_arbiter: directed bench for ahb_req_arbiter (NUM_MASTERS=2)
// with a completion scoreboard of expected master/error/read-data.
module tb_ahb_req_arbiter;

   logic        Hclk;
   logic        Hreset;
   logic [1:0]  m_req;
   logic [63:0] m_addr;
   logic [1:0]  m_write;
   logic [63:0] m_wdata;
   logic [1:0]  m_gnt;
   logic [1:0]  m_ack;
   logic        m_err;
   logic [31:0] m_rdata;
   logic        busy;
   logic [31:0] Haddr;
   logic        Hwrite;
   logic [1:0]  Htrans;
   logic [31:0] Hwdata;
   logic        Hreadyin;
   logic        Hreadyout;
   logic [1:0]  Hresp;
   logic [31:0] Hrdata;

   typedef struct {
      int          idx;
      logic        err;
      logic [31:0] rd;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_rd = '0;
   logic [1:0]  prev_ack = '0;

   ahb_req_arbiter dut (
      .Hclk      (Hclk),
      .Hreset    (Hreset),
      .m_req     (m_req),
      .m_addr    (m_addr),
      .m_write   (m_write),
      .m_wdata   (m_wdata),
      .m_gnt     (m_gnt),
      .m_ack     (m_ack),
      .m_err     (m_err),
      .m_rdata   (m_rdata),
      .busy      (busy),
      .Haddr     (Haddr),
      .Hwrite    (Hwrite),
      .Htrans    (Htrans),
      .Hwdata    (Hwdata),
      .Hreadyin  (Hreadyin),
      .Hreadyout (Hreadyout),
      .Hresp     (Hresp),
      .Hrdata    (Hrdata)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic push(input int idx, input logic err, input logic [31:0] rd);
      exp_t e;
      e.idx = idx;
      e.err = err;
      e.rd  = rd;
      sb.push_back(e);
   endtask

   // Completion monitor: every ack must match the oldest expectation.
   always @(negedge Hclk) begin
      exp_t e;
      if (prev_ack !== 2'b00) begin
         chk("ack_pulse_width", {30'd0, m_ack}, 32'd0);
      end else if (m_ack !== 2'b00) begin
         if (sb.size() == 0) begin
            chk("ack_unexpected", {30'd0, m_ack}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_ack_master", {30'd0, m_ack}, 32'(2'b01 << e.idx));
            chk("sb_err", {31'd0, m_err}, {31'd0, e.err});
            chk("sb_rdata", m_rdata, e.rd);
         end
      end
      prev_ack = m_ack;
   end

   initial begin
      Hreset    = 1'b1;
      m_req     = '0;
      m_addr    = '0;
      m_write   = '0;
      m_wdata   = '0;
      Hreadyout = 1'b1;
      Hresp     = 2'b00;
      Hrdata    = '0;
      tick();
      tick();
      chk("rst_gnt", {30'd0, m_gnt}, 32'd0);
      chk("rst_ack", {30'd0, m_ack}, 32'd0);
      chk("rst_err", {31'd0, m_err}, 32'd0);
      chk("rst_rdata", m_rdata, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_haddr", Haddr, 32'd0);
      chk("rst_hwrite", {31'd0, Hwrite}, 32'd0);
      chk("rst_htrans", {30'd0, Htrans}, 32'd0);
      chk("rst_hwdata", Hwdata, 32'd0);
      chk("rst_hreadyin", {31'd0, Hreadyin}, 32'd1);
      Hreset = 1'b0;

      // Single write from master0, no wait states.
      m_addr[31:0]  = 32'h8000_0004;
      m_wdata[31:0] = 32'hA5A5_5A5A;
      m_write       = 2'b01;
      m_req         = 2'b01;
      push(0, 1'b0, exp_rd);
      tick();
      chk("wr_htrans_addr", {30'd0, Htrans}, 32'd2);
      chk("wr_haddr", Haddr, 32'h8000_0004);
      chk("wr_hwrite", {31'd0, Hwrite}, 32'd1);
      chk("wr_gnt", {30'd0, m_gnt}, 32'd1);
      chk("wr_busy", {31'd0, busy}, 32'd1);
      chk("wr_ack_c1", {30'd0, m_ack}, 32'd0);
      tick();
      chk("wr_htrans_data", {30'd0, Htrans}, 32'd0);
      chk("wr_hwdata", Hwdata, 32'hA5A5_5A5A);
      chk("wr_ack_c2", {30'd0, m_ack}, 32'd0);
      tick();
      chk("wr_ack_c3", {30'd0, m_ack}, 32'd1);
      chk("wr_err", {31'd0, m_err}, 32'd0);
      m_req = 2'b00;
      tick();
      chk("wr_idle_busy", {31'd0, busy}, 32'd0);

      // Fairness from reset: both requesting, grants alternate 0,1,0,1.
      Hreset = 1'b1;
      tick();
      Hreset = 1'b0;
      exp_rd = '0;
      m_addr  = {32'h8100_0010, 32'h8100_0000};
      m_wdata = {32'h1111_1111, 32'h0000_0000};
      m_write = 2'b11;
      m_req   = 2'b11;
      for (int n = 0; n < 4; n++) begin
         push(n % 2, 1'b0, exp_rd);
      end
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("fair_gnt", {30'd0, m_gnt}, (n % 2 == 0) ? 32'd1 : 32'd2);
         tick();
         tick();
         chk("fair_ack", {30'd0, m_ack}, (n % 2 == 0) ? 32'd1 : 32'd2);
      end
      m_req = 2'b00;
      tick();

      // Read from master1 with 3 wait states in DATA.
      m_addr[63:32] = 32'h8400_0000;
      m_write       = 2'b00;
      m_req         = 2'b10;
      Hrdata        = 32'hDEAD_BEEF;
      exp_rd        = 32'hDEAD_BEEF;
      push(1, 1'b0, exp_rd);
      tick();
      chk("rd_htrans", {30'd0, Htrans}, 32'd2);
      chk("rd_haddr", Haddr, 32'h8400_0000);
      chk("rd_hwrite", {31'd0, Hwrite}, 32'd0);
      tick();
      Hreadyout = 1'b0;
      chk("rd_htrans_data", {30'd0, Htrans}, 32'd0);
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("rd_wait_ack", {30'd0, m_ack}, 32'd0);
         chk("rd_wait_busy", {31'd0, busy}, 32'd1);
      end
      Hreadyout = 1'b1;
      tick();
      chk("rd_ack_c6", {30'd0, m_ack}, 32'd2);
      chk("rd_rdata", m_rdata, 32'hDEAD_BEEF);
      m_req  = 2'b00;
      Hrdata = '0;
      tick();

      // Error response, with one ADDR stall; rr_ptr must still advance.
      m_addr[31:0] = 32'h8000_0100;
      m_write      = 2'b01;
      m_req        = 2'b01;
      Hreadyout    = 1'b0;
      push(0, 1'b1, exp_rd);
      tick();
      chk("err_htrans", {30'd0, Htrans}, 32'd2);
      tick();
      chk("err_addr_hold_htrans", {30'd0, Htrans}, 32'd2);
      chk("err_addr_hold_haddr", Haddr, 32'h8000_0100);
      Hreadyout = 1'b1;
      Hresp     = 2'b01;
      tick();
      tick();
      chk("err_ack", {30'd0, m_ack}, 32'd1);
      chk("err_flag", {31'd0, m_err}, 32'd1);
      m_req = 2'b00;
      Hresp = 2'b00;
      tick();

      // Reset during DATA: no ack, then master0 wins again.
      m_req = 2'b11;
      tick();
      chk("rr_after_err_gnt", {30'd0, m_gnt}, 32'd2);
      tick();
      Hreadyout = 1'b0;
      tick();
      Hreset = 1'b1;
      tick();
      chk("rstd_ack", {30'd0, m_ack}, 32'd0);
      chk("rstd_htrans", {30'd0, Htrans}, 32'd0);
      chk("rstd_gnt", {30'd0, m_gnt}, 32'd0);
      chk("rstd_busy", {31'd0, busy}, 32'd0);
      Hreset    = 1'b0;
      Hreadyout = 1'b1;
      exp_rd    = '0;
      push(0, 1'b0, exp_rd);
      tick();
      chk("rstd_regnt", {30'd0, m_gnt}, 32'd1);
      tick();
      tick();
      chk("rstd_ack_m0", {30'd0, m_ack}, 32'd1);
      m_req = 2'b00;
      tick();

      // Stalled bridge: forced completion or indefinite wait.
      m_write   = 2'b00;
      Hrdata    = 32'h1234_5678;
      Hreadyout = 1'b0;
      m_req     = 2'b10;
`ifdef ARB_TIMEOUT_EN
      push(1, 1'b1, exp_rd);
`endif
      tick();
      chk("to_gnt", {30'd0, m_gnt}, 32'd2);
`ifdef ARB_TIMEOUT_EN
      for (int n = 0; n < 15; n++) begin
         tick();
         chk("to_no_ack", {30'd0, m_ack}, 32'd0);
      end
      tick();
      chk("to_ack", {30'd0, m_ack}, 32'd2);
      chk("to_err", {31'd0, m_err}, 32'd1);
      chk("to_rdata", m_rdata, exp_rd);
      m_req = 2'b00;
      tick();
`else
      for (int n = 0; n < 40; n++) begin
         tick();
      end
      chk("to_busy_hold", {31'd0, busy}, 32'd1);
      chk("to_gnt_hold", {30'd0, m_gnt}, 32'd2);
      m_req  = 2'b00;
      Hreset = 1'b1;
      tick();
      Hreset = 1'b0;
`endif
      Hreadyout = 1'b1;
      tick();
      tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
